spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on SPI_Clk, SPI_Cs and SPI_Di (legal range 2..3).
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF, giving the byte shifted out when no transmit byte is queued.
REQ-003 Clk  input  1  system clock; single clock domain; must run at least 4x SPI_Clk.
REQ-004 Reset  input  1  reset; asynchronous, active-high.
REQ-005 SPI_Clk  input  1  SPI clock from the host; mode 0: idle low, MOSI sampled on rising edge.
REQ-006 SPI_Cs  input  1  chip select from the host, active low.
REQ-007 SPI_Di  input  1  MOSI, data from the host.
REQ-008 SPI_Do  output  1  MISO, data to the host.
REQ-009 SPI_DoOe  output  1  MISO output enable; high only while selected.
REQ-010 TxData  input  8  next byte to send to the host.
REQ-011 TxLoad  input  1  single-cycle strobe writing TxData into the transmit holding register.
REQ-012 TxFull  output  1  holding register occupied, not yet consumed.
REQ-013 RxData  output  8  last complete byte received from the host.
REQ-014 RxValid  output  1  single-cycle strobe: RxData updated.
REQ-015 Selected  output  1  synchronized chip select asserted (active high).
REQ-016 Underrun  output  1  single-cycle strobe: IDLE_BYTE substituted at a byte start.

Function
REQ-017 SHALL pass SPI_Clk, SPI_Cs and SPI_Di through SYNC_STAGES flops, then one extra history flop for edge detection; all events below act on the synchronized signals.
REQ-018 SHALL implement states IDLE (Cs high) and ACTIVE (Cs low) with a 3-bit bit counter; IDLE->ACTIVE on synchronized Cs falling, ACTIVE->IDLE on synchronized Cs rising.
REQ-019 On IDLE->ACTIVE: bit counter <= 0; tx shift register <= holding register if TxFull (TxFull <= 0), else IDLE_BYTE (Underrun pulse).
REQ-020 SPI_Do SHALL equal tx shift register bit 7 at all times; SPI_DoOe SHALL equal Selected.
REQ-021 On SCK rising edge in ACTIVE: rx shift register <= {rx[6:0], Di}; bit counter +1 (wraps 7->0).
REQ-022 On the rising edge where the counter wraps 7->0: RxData <= {rx[6:0], Di} and RxValid = 1 for exactly one Clk cycle, SYNC_STAGES+1 Clk edges after the pin edge.
REQ-023 On SCK falling edge in ACTIVE: if bit counter = 0, reload tx shift register per REQ-019 rule; else shift tx shift register left by one, filling 1.
REQ-024 SCK edges while IDLE SHALL be ignored; no shifting, no strobes.
REQ-025 Cs rising mid-byte SHALL abort: partial byte discarded, no RxValid, bit counter <= 0, holding register and TxFull unchanged.
REQ-026 TxLoad while TxFull = 1 SHALL overwrite the holding register; TxFull stays 1.
REQ-027 TxLoad in the same cycle as a reload SHALL let the reload take the old holding content (or IDLE_BYTE if empty), then store TxData with TxFull = 1.
REQ-028 Cs falling and SCK rising in the same synchronized cycle SHALL apply REQ-019 first, then REQ-021.

Reset
REQ-029 While Reset is high: state IDLE, counter 0, SPI_Do = 1, SPI_DoOe = 0, TxFull = 0, RxData = 8'h00, RxValid = 0, Selected = 0, Underrun = 0, tx shift register = IDLE_BYTE, synchronizers at idle levels (Cs = 1, Clk = 0).
REQ-030 Reset mid-transfer SHALL take effect immediately; after release, the block waits for a fresh Cs falling edge before shifting.

Verification
REQ-031 TxLoad 8'hA5, Cs low, host sends 8'h3C at Clk/8 -> MISO sees 8'hA5 MSB first, one RxValid with RxData = 8'h3C, TxFull 1->0.
REQ-032 No TxLoad, two-byte transfer 8'h01, 8'h80 -> MISO 8'hFF 8'hFF, Underrun twice, RxValid twice with 8'h01 then 8'h80.
REQ-033 Cs high after 5 SCK edges -> no RxValid; next full byte 8'h55 received correctly.
REQ-034 TxLoad 8'h11 then 8'h22 before Cs falls -> MISO sends 8'h22; TxLoad coincident with a reload -> next byte sent and holding both correct.
REQ-035 SCK toggled with Cs high -> no RxValid, SPI_DoOe stays 0.
REQ-036 Reset asserted after 3 bits -> all outputs at REQ-029 values in the same cycle; next full transfer correct.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronized pins, byte-wide rx strobe and
// tx holding register with idle-byte substitution on underrun.
//
// Ports:
//   Clk, Reset           system clock, async active-high reset
//   SPI_Clk/Cs/Di        host-side SPI pins (asynchronous)
//   SPI_Do, SPI_DoOe     MISO and its output enable
//   TxData, TxLoad       write strobe into transmit holding register
//   TxFull               holding register occupied
//   RxData, RxValid      last received byte and its one-cycle strobe
//   Selected             synchronized chip select (active high)
//   Underrun             IDLE_BYTE substituted at a byte start
module spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SPI_Clk,
  input  logic       SPI_Cs,
  input  logic       SPI_Di,
  output logic       SPI_Do,
  output logic       SPI_DoOe,
  input  logic [7:0] TxData,
  input  logic       TxLoad,
  output logic       TxFull,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       Selected,
  output logic       Underrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] di_sync_q;
  logic                   sck_h_q;
  logic                   cs_h_q;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       rxvalid_q, rxvalid_d;
  logic       underrun_q, underrun_d;

  logic sck_s, cs_s, di_s;
  logic sck_rise, sck_fall;
  logic cs_fall, cs_rise;
  logic reload;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign di_s  = di_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_h_q;
  assign sck_fall = ~sck_s & sck_h_q;
  assign cs_fall  = ~cs_s & cs_h_q;
  assign cs_rise  = cs_s & ~cs_h_q;

  // Pin synchronizers plus one history stage for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      di_sync_q  <= '0;
      sck_h_q    <= 1'b0;
      cs_h_q     <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SPI_Clk};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], SPI_Cs};
      di_sync_q  <= {di_sync_q[SYNC_STAGES-2:0], SPI_Di};
      sck_h_q    <= sck_s;
      cs_h_q     <= cs_s;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      tx_q       <= IDLE_BYTE;
      rx_q       <= 7'd0;
      hold_q     <= 8'd0;
      full_q     <= 1'b0;
      rxdata_q   <= 8'd0;
      rxvalid_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      rxdata_q   <= rxdata_d;
      rxvalid_q  <= rxvalid_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    hold_d     = hold_q;
    full_d     = full_q;
    rxdata_d   = rxdata_q;
    rxvalid_d  = 1'b0;
    underrun_d = 1'b0;
    reload     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          reload  = 1'b1;
          // A coincident SCK rise counts as bit 0 of the new byte.
          if (sck_rise) begin
            rx_d  = {rx_q[5:0], di_s};
            cnt_d = 3'd1;
          end else begin
            cnt_d = 3'd0;
          end
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Abort: partial byte is dropped, holding register kept.
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (sck_rise) begin
          rx_d  = {rx_q[5:0], di_s};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rxdata_d  = {rx_q, di_s};
            rxvalid_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (cnt_q == 3'd0) begin
            reload = 1'b1;
          end else begin
            tx_d = {tx_q[6:0], 1'b1};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      if (full_q) begin
        tx_d   = hold_q;
        full_d = 1'b0;
      end else begin
        tx_d       = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end

    // A load in the reload cycle refills after the old content is taken.
    if (TxLoad) begin
      hold_d = TxData;
      full_d = 1'b1;
    end
  end

  assign SPI_Do   = tx_q[7];
  assign Selected = (state_q == ACTIVE);
  assign SPI_DoOe = Selected;
  assign TxFull   = full_q;
  assign RxData   = rxdata_q;
  assign RxValid  = rxvalid_q;
  assign Underrun = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: host-side SPI driver, rx-byte
// scoreboard queue and MISO/flag checks with immediate assertions.
module tb_spi_target;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       SPI_Clk, SPI_Cs, SPI_Di;
  logic       SPI_Do, SPI_DoOe;
  logic [7:0] TxData;
  logic       TxLoad;
  logic       TxFull;
  logic [7:0] RxData;
  logic       RxValid, Selected, Underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ur_cnt   = 0;
  logic [7:0] exp_rx[$];

  spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .Clk(Clk), .Reset(Reset),
    .SPI_Clk(SPI_Clk), .SPI_Cs(SPI_Cs), .SPI_Di(SPI_Di),
    .SPI_Do(SPI_Do), .SPI_DoOe(SPI_DoOe),
    .TxData(TxData), .TxLoad(TxLoad), .TxFull(TxFull),
    .RxData(RxData), .RxValid(RxValid),
    .Selected(Selected), .Underrun(Underrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RxValid pulse must match the oldest expected byte.
  always @(negedge Clk) begin
    if (RxValid === 1'b1) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
      else chk("rxdata", {24'd0, RxData}, {24'd0, exp_rx.pop_front()});
    end
    if (Underrun === 1'b1) ur_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge Clk);
    TxData = d;
    TxLoad = 1'b1;
    @(negedge Clk);
    TxLoad = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge Clk);
    SPI_Cs = 1'b0;
    cyc(6);
  endtask

  // Host transfer of nbits MSB first. With end_cs the final SCK fall
  // and the Cs rise land together, so no trailing reload happens.
  // With do_co a TxLoad of co is timed onto the reload of the last fall.
  task automatic xfer(input logic [7:0] mosi, input int nbits,
                      input bit end_cs, input bit do_co,
                      input logic [7:0] co, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      SPI_Di = mosi[7-i];
      cyc(HALF);
      miso[7-i] = SPI_Do;
      SPI_Clk = 1'b1;
      cyc(HALF);
      SPI_Clk = 1'b0;
      if (i == nbits - 1 && end_cs) SPI_Cs = 1'b1;
      if (i == nbits - 1 && do_co) begin
        cyc(SYNC);
        TxData = co;
        TxLoad = 1'b1;
        cyc(1);
        TxLoad = 1'b0;
        cyc(HALF - SYNC - 1);
      end else begin
        cyc(HALF);
      end
    end
    cyc(2);
  endtask

  logic [7:0] m1, m2;
  int ur0;

  initial begin
    Reset = 1'b1; SPI_Clk = 1'b0; SPI_Cs = 1'b1; SPI_Di = 1'b0;
    TxData = 8'h00; TxLoad = 1'b0;
    cyc(3);
    chk("rst_do", {31'd0, SPI_Do}, 32'd1);
    chk("rst_oe", {31'd0, SPI_DoOe}, 32'd0);
    chk("rst_full", {31'd0, TxFull}, 32'd0);
    chk("rst_rxdata", {24'd0, RxData}, 32'd0);
    chk("rst_sel", {31'd0, Selected}, 32'd0);
    Reset = 1'b0;
    cyc(3);

    // Single byte with a preloaded transmit byte.
    load(8'hA5);
    chk("t1_full_set", {31'd0, TxFull}, 32'd1);
    cs_low();
    chk("t1_full_clr", {31'd0, TxFull}, 32'd0);
    chk("t1_sel", {31'd0, Selected}, 32'd1);
    chk("t1_oe", {31'd0, SPI_DoOe}, 32'd1);
    chk("t1_no_ur", ur_cnt, 32'd0);
    exp_rx.push_back(8'h3C);
    xfer(8'h3C, 8, 1, 0, 8'h00, m1);
    chk("t1_miso", {24'd0, m1}, 32'hA5);
    cyc(4);
    chk("t1_desel", {31'd0, Selected}, 32'd0);

    // Two bytes with nothing queued: idle byte twice.
    ur0 = ur_cnt;
    cs_low();
    exp_rx.push_back(8'h01);
    xfer(8'h01, 8, 0, 0, 8'h00, m1);
    exp_rx.push_back(8'h80);
    xfer(8'h80, 8, 1, 0, 8'h00, m2);
    chk("t2_miso0", {24'd0, m1}, 32'hFF);
    chk("t2_miso1", {24'd0, m2}, 32'hFF);
    chk("t2_underruns", ur_cnt - ur0, 32'd2);
    cyc(4);

    // Abort after five SCK edges; holding register survives.
    cs_low();
    load(8'h77);
    xfer(8'hE0, 3, 1, 0, 8'h00, m1);
    cyc(4);
    chk("t3_full_kept", {31'd0, TxFull}, 32'd1);
    chk("t3_desel", {31'd0, Selected}, 32'd0);
    cs_low();
    exp_rx.push_back(8'h55);
    xfer(8'h55, 8, 1, 0, 8'h00, m1);
    chk("t3_miso", {24'd0, m1}, 32'h77);
    cyc(4);

    // Overwrite before select, then a load coincident with a reload.
    load(8'h11);
    load(8'h22);
    chk("t4_full", {31'd0, TxFull}, 32'd1);
    cs_low();
    load(8'h33);
    exp_rx.push_back(8'hA1);
    xfer(8'hA1, 8, 0, 1, 8'h44, m1);
    exp_rx.push_back(8'h5E);
    xfer(8'h5E, 8, 1, 0, 8'h00, m2);
    chk("t4_miso0", {24'd0, m1}, 32'h22);
    chk("t4_miso1", {24'd0, m2}, 32'h33);
    chk("t4_full_co", {31'd0, TxFull}, 32'd1);
    cyc(4);
    cs_low();
    exp_rx.push_back(8'h0F);
    xfer(8'h0F, 8, 1, 0, 8'h00, m1);
    chk("t4_miso2", {24'd0, m1}, 32'h44);
    chk("t4_full_end", {31'd0, TxFull}, 32'd0);
    cyc(4);

    // SCK activity while deselected is ignored.
    ur0 = ur_cnt;
    for (int i = 0; i < 8; i++) begin
      SPI_Clk = 1'b1;
      cyc(HALF);
      chk("t5_oe", {31'd0, SPI_DoOe}, 32'd0);
      SPI_Clk = 1'b0;
      cyc(HALF);
    end
    chk("t5_sel", {31'd0, Selected}, 32'd0);
    chk("t5_no_ur", ur_cnt - ur0, 32'd0);

    // Reset in the middle of a byte.
    load(8'h9A);
    cs_low();
    load(8'hBB);
    xfer(8'hF0, 3, 0, 0, 8'h00, m1);
    Reset = 1'b1;
    SPI_Cs = 1'b1;
    #1;
    chk("t6_do", {31'd0, SPI_Do}, 32'd1);
    chk("t6_oe", {31'd0, SPI_DoOe}, 32'd0);
    chk("t6_full", {31'd0, TxFull}, 32'd0);
    chk("t6_rxdata", {24'd0, RxData}, 32'd0);
    chk("t6_rxvalid", {31'd0, RxValid}, 32'd0);
    chk("t6_sel", {31'd0, Selected}, 32'd0);
    chk("t6_ur", {31'd0, Underrun}, 32'd0);
    cyc(3);
    Reset = 1'b0;
    cyc(6);
    chk("t6_still_idle", {31'd0, Selected}, 32'd0);
    cs_low();
    exp_rx.push_back(8'hC3);
    xfer(8'hC3, 8, 1, 0, 8'h00, m1);
    chk("t6_miso", {24'd0, m1}, 32'hFF);

    cyc(10);
    chk("sb_drained", exp_rx.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
